// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, response owner
// encoding and the record used to steer the winning request to the SRAM.
package dmem_arb_pkg;

    localparam int unsigned DMEM_XLEN = 32;

    typedef enum logic {
        ARB_IDLE      = 1'b0,
        ARB_DMA_BURST = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } arb_owner_e;

    typedef struct packed {
        logic [DMEM_XLEN-1:0] addr;
        logic [DMEM_XLEN-1:0] wdata;
        logic [3:0]           be;
        logic                 we;
    } mem_req_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Data SRAM arbiter between the core data port and the DMA engine.
// Handshake: a requester holds *_req_i and its request fields stable; the
// matching *_gnt_o rises combinationally in the same cycle when the access is
// issued to the SRAM. Read data returns on *_rdata_o one cycle later, flagged
// by *_rvalid_o for exactly one cycle. Writes produce no response.
// dbg_state_o exposes the FSM state for checkers.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned XLEN      = DMEM_XLEN,
    parameter int unsigned MAX_WAIT  = 8,
    parameter int unsigned BURST_MAX = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            core_req_i,
    output logic            core_gnt_o,
    input  logic [XLEN-1:0] core_addr_i,
    input  logic [XLEN-1:0] core_wdata_i,
    input  logic [3:0]      core_size_i,
    input  logic            core_read_i,
    input  logic            core_write_i,
    output logic [XLEN-1:0] core_rdata_o,
    output logic            core_rvalid_o,

    input  logic            dma_req_i,
    input  logic            dma_lock_i,
    output logic            dma_gnt_o,
    input  logic [XLEN-1:0] dma_addr_i,
    input  logic [XLEN-1:0] dma_wdata_i,
    input  logic [3:0]      dma_size_i,
    input  logic            dma_write_i,
    output logic [XLEN-1:0] dma_rdata_o,
    output logic            dma_rvalid_o,

    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [3:0]      mem_be_o,
    input  logic [XLEN-1:0] mem_rdata_i,

    output logic            dbg_state_o
);

    // The steering record is sized by the package width.
    if (XLEN != DMEM_XLEN) begin : g_width_check
        $error("dmem_arbiter: XLEN must equal DMEM_XLEN");
    end

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int unsigned BEAT_W = $clog2(BURST_MAX + 1);

    arb_state_e  state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    arb_owner_e  rsp_owner_q, rsp_owner_d;
    logic        boost;
    mem_req_t    win;

    // DMA has been refused long enough to take priority over the core.
    assign boost = (wait_cnt_q == WAIT_W'(MAX_WAIT));

    // State register, starvation counter, burst beat counter, response owner.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            wait_cnt_q  <= '0;
            beat_cnt_q  <= '0;
            rsp_owner_q <= OWN_NONE;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end

    // Grant decision: same-cycle, at most one winner, nothing during reset.
    always_comb begin
        core_gnt_o = 1'b0;
        dma_gnt_o  = 1'b0;
        if (!rst_i) begin
            case (state_q)
                ARB_IDLE: begin
                    // Boost only matters when DMA is actually competing.
                    core_gnt_o = core_req_i && !(boost && dma_req_i);
                    dma_gnt_o  = dma_req_i && !core_gnt_o;
                end
                ARB_DMA_BURST: begin
                    dma_gnt_o = dma_req_i;
                end
                default: begin
                    core_gnt_o = 1'b0;
                    dma_gnt_o  = 1'b0;
                end
            endcase
        end
    end

    // Next state: enter/leave locked bursts, bound burst length, track starvation.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                // A locked first beat opens a burst, unless one beat is already the limit.
                if (dma_gnt_o && dma_lock_i && (BURST_MAX > 1)) begin
                    state_d    = ARB_DMA_BURST;
                    beat_cnt_d = BEAT_W'(1);
                end
            end
            ARB_DMA_BURST: begin
                if (!dma_lock_i) begin
                    state_d    = ARB_IDLE;
                    beat_cnt_d = '0;
                end else if (dma_gnt_o) begin
                    if (beat_cnt_q == BEAT_W'(BURST_MAX - 1)) begin
                        // Forced release: give the core one arbitration slot.
                        state_d    = ARB_IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                beat_cnt_d = '0;
            end
        endcase

        if (dma_gnt_o || !dma_req_i) begin
            wait_cnt_d = '0;
        end else if (!boost) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        // A core access flagged both read and write is treated as a write.
        if (core_gnt_o && core_read_i && !core_write_i) begin
            rsp_owner_d = OWN_CORE;
        end else if (dma_gnt_o && !dma_write_i) begin
            rsp_owner_d = OWN_DMA;
        end else begin
            rsp_owner_d = OWN_NONE;
        end
    end

    // SRAM drive: the winner's request, or all zeros when nobody is granted.
    always_comb begin
        win = '0;
        if (core_gnt_o) begin
            win.addr  = core_addr_i;
            win.wdata = core_wdata_i;
            win.be    = core_size_i;
            win.we    = core_write_i;
        end else if (dma_gnt_o) begin
            win.addr  = dma_addr_i;
            win.wdata = dma_wdata_i;
            win.be    = dma_size_i;
            win.we    = dma_write_i;
        end
    end

    assign mem_en_o    = core_gnt_o | dma_gnt_o;
    assign mem_we_o    = win.we;
    assign mem_addr_o  = win.addr;
    assign mem_wdata_o = win.wdata;
    assign mem_be_o    = win.be;

    // Read data goes to both requesters; rvalid names the owner.
    assign core_rdata_o  = mem_rdata_i;
    assign dma_rdata_o   = mem_rdata_i;
    assign core_rvalid_o = (rsp_owner_q == OWN_CORE);
    assign dma_rvalid_o  = (rsp_owner_q == OWN_DMA);

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic,
// checked against a behavioural arbitration model and a reference memory.
module tb_dmem_arbiter;

    localparam int XLEN      = 32;
    localparam int MAX_WAIT  = 8;
    localparam int BURST_MAX = 16;
    localparam int WORDS     = 128;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            core_req, core_gnt, core_read, core_write, core_rvalid;
    logic [XLEN-1:0] core_addr, core_wdata, core_rdata;
    logic [3:0]      core_size;
    logic            dma_req, dma_lock, dma_gnt, dma_write, dma_rvalid;
    logic [XLEN-1:0] dma_addr, dma_wdata, dma_rdata;
    logic [3:0]      dma_size;
    logic            mem_en, mem_we;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]      mem_be;
    logic            dbg_state;

    dmem_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
        .clk_i(clk), .rst_i(rst),
        .core_req_i(core_req), .core_gnt_o(core_gnt), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_size_i(core_size), .core_read_i(core_read),
        .core_write_i(core_write), .core_rdata_o(core_rdata), .core_rvalid_o(core_rvalid),
        .dma_req_i(dma_req), .dma_lock_i(dma_lock), .dma_gnt_o(dma_gnt),
        .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata), .dma_size_i(dma_size),
        .dma_write_i(dma_write), .dma_rdata_o(dma_rdata), .dma_rvalid_o(dma_rvalid),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata),
        .dbg_state_o(dbg_state)
    );

    // ---------------- SRAM attached to the DUT ----------------
    logic [XLEN-1:0] sram    [WORDS];
    logic [XLEN-1:0] ref_mem [WORDS];
    logic [XLEN-1:0] rd_q = '0;
    assign mem_rdata = rd_q;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                rd_q <= sram[mem_addr[8:2]];
            end
        end
    end

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int miscompares = 0;
    logic [XLEN-1:0] core_exp_q[$];
    logic [XLEN-1:0] dma_exp_q[$];
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: whether DMA holds a lock, beats issued under that lock,
    // and consecutive cycles DMA has been refused.
    bit m_locked   = 1'b0;
    int m_beats    = 0;
    int m_refused  = 0;

    task automatic model_and_check();
        bit e_core, e_dma, starving;
        logic [XLEN-1:0] e_addr, e_wdata;
        logic [3:0] e_be;
        logic e_we;
        e_core = 1'b0;
        e_dma  = 1'b0;
        if (!rst) begin
            if (m_locked) begin
                e_dma = dma_req;
            end else begin
                starving = (m_refused >= MAX_WAIT) && dma_req;
                e_core = core_req && !starving;
                e_dma  = dma_req && !e_core;
            end
        end
        e_addr = '0; e_wdata = '0; e_be = '0; e_we = 1'b0;
        if (e_core) begin
            e_addr = core_addr; e_wdata = core_wdata; e_be = core_size; e_we = core_write;
        end else if (e_dma) begin
            e_addr = dma_addr; e_wdata = dma_wdata; e_be = dma_size; e_we = dma_write;
        end

        check("core_gnt",  32'(core_gnt),  32'(e_core));
        check("dma_gnt",   32'(dma_gnt),   32'(e_dma));
        check("mem_en",    32'(mem_en),    32'(e_core | e_dma));
        check("mem_we",    32'(mem_we),    32'(e_we));
        check("mem_addr",  mem_addr,       e_addr);
        check("mem_wdata", mem_wdata,      e_wdata);
        check("mem_be",    32'(mem_be),    32'(e_be));
        check("state",     32'(dbg_state), 32'(m_locked));

        // Reference memory and expected read responses.
        if (e_core || e_dma) begin
            if (e_we) begin
                for (int b = 0; b < 4; b++)
                    if (e_be[b]) ref_mem[e_addr[8:2]][8*b +: 8] = e_wdata[8*b +: 8];
            end else if (e_core && core_read) begin
                core_exp_q.push_back(ref_mem[e_addr[8:2]]);
            end else if (e_dma) begin
                dma_exp_q.push_back(ref_mem[e_addr[8:2]]);
            end
        end

        // Advance the model to the next cycle.
        if (rst) begin
            m_locked = 1'b0; m_beats = 0; m_refused = 0;
        end else begin
            if (e_dma || !dma_req) m_refused = 0;
            else if (m_refused < MAX_WAIT) m_refused++;
            if (!m_locked) begin
                if (e_dma && dma_lock) begin
                    m_beats  = 1;
                    m_locked = 1'b1;
                end
            end else if (!dma_lock) begin
                m_locked = 1'b0;
            end else if (e_dma) begin
                m_beats++;
            end
            if (m_locked && m_beats >= BURST_MAX) m_locked = 1'b0;
            if (!m_locked) m_beats = 0;
        end
    endtask

    // Monitor: each cycle the response owed for the previous cycle's grant.
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            check("core_rvalid", 32'(core_rvalid), 32'(core_exp_q.size() != 0));
            if (core_rvalid && core_exp_q.size() != 0) check("core_rdata", core_rdata, core_exp_q.pop_front());
            core_exp_q.delete();
            check("dma_rvalid", 32'(dma_rvalid), 32'(dma_exp_q.size() != 0));
            if (dma_rvalid && dma_exp_q.size() != 0) check("dma_rdata", dma_rdata, dma_exp_q.pop_front());
            dma_exp_q.delete();
        end
    end

    // Illegal core command guard.
    always @(negedge clk) begin
        if (!rst && core_req) assert (!(core_read && core_write)) else $error("core read and write both set");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        model_and_check();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cr, input logic c_wr, input logic [31:0] c_addr,
                         input logic dr, input logic dl, input logic d_wr, input logic [31:0] d_addr);
        core_req = cr; core_read = cr && !c_wr; core_write = cr && c_wr;
        core_addr = c_addr; core_wdata = $urandom; core_size = 4'hF;
        dma_req = dr; dma_lock = dl; dma_write = d_wr;
        dma_addr = d_addr; dma_wdata = $urandom; dma_size = 4'hF;
        step();
    endtask

    task automatic drive_random();
        int k;
        rst = ($urandom_range(0, 199) == 0);
        core_req = ($urandom_range(0, 9) < 6);
        k = $urandom_range(0, 3);
        core_read  = (k < 2);
        core_write = (k == 2);
        core_addr  = {23'd0, 7'($urandom_range(0, WORDS - 1)), 2'b00};
        core_wdata = $urandom;
        core_size  = 4'($urandom_range(1, 15));
        dma_req    = ($urandom_range(0, 9) < 5);
        dma_lock   = ($urandom_range(0, 9) < 7);
        dma_write  = ($urandom_range(0, 1) == 1);
        dma_addr   = {23'd0, 7'($urandom_range(0, WORDS - 1)), 2'b00};
        dma_wdata  = $urandom;
        dma_size   = 4'($urandom_range(1, 15));
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < WORDS; i++) begin
            sram[i]    = 32'hA5000000 ^ (i * 32'h00010203);
            ref_mem[i] = 32'hA5000000 ^ (i * 32'h00010203);
        end
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 32'h10, 1, 0, 0, 32'h20);   // grants must stay low in reset
        mon_en = 1'b1;
        rst = 1'b0;

        // Lone core load, then idle so its response is observed.
        drive(1, 0, 32'h10, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Core and DMA together for 3 cycles, then DMA alone.
        for (int i = 0; i < 3; i++) drive(1, 0, 32'h10 + 4 * i, 1, 0, 0, 32'h40);
        drive(0, 0, 0, 1, 0, 0, 32'h40);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Continuous contention: boost on the 9th cycle.
        for (int i = 0; i < 12; i++) drive(1, i[0], 32'h80 + 4 * i, 1, 0, 0, 32'h44);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Locked 4-beat DMA write burst while the core waits.
        drive(0, 0, 0, 1, 1, 1, 32'h100);
        drive(1, 0, 32'h8, 1, 1, 1, 32'h104);
        drive(1, 0, 32'h8, 1, 1, 1, 32'h108);
        drive(1, 0, 32'h8, 1, 0, 1, 32'h10C);
        drive(1, 0, 32'h100, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // 20 locked beats: forced release after 16, core slips in, DMA re-locks.
        for (int c = 0; c <= 20; c++)
            drive(c >= 1 && c <= 16, 0, 32'h104, 1, c < 20, c[0], 32'h140 + 4 * (c % 16));
        // Held bus with no DMA request.
        drive(0, 0, 0, 1, 1, 0, 32'h60);
        drive(1, 0, 32'h64, 0, 1, 0, 0);
        drive(1, 0, 32'h64, 1, 0, 0, 32'h68);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Reset one cycle after a DMA read grant inside a burst.
        drive(0, 0, 0, 1, 1, 0, 32'h20);
        drive(0, 0, 0, 1, 1, 0, 32'h24);
        rst = 1'b1;
        drive(1, 0, 32'h28, 1, 1, 0, 32'h2C);
        drive(1, 0, 32'h28, 1, 1, 0, 32'h2C);
        rst = 1'b0;
        drive(1, 0, 32'h28, 1, 1, 0, 32'h2C);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) drive_random();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
